tc_mul_lanes: RTL

- Next-generation tensor-core multiply stage: NUM_LANES parallel integer multipliers behind a single valid/ready handshake.
- Runtime per-transaction controls: signed/unsigned mode, lane-enable mask, optional lane reduction (dot-product partial sum).
- Control sideband is pipelined in lock-step with the data, not passed through combinationally.
- Sits between the operand-collector and the tensor-core accumulator stage.

---
 rtl/tc_mul_lanes_pkg.sv | 30 +++
 rtl/tc_mul_lanes_if.sv | 40 ++++
 rtl/tc_mul_lanes_stage.sv | 29 ++
 rtl/tc_mul_lanes.sv | 115 +++++++++++
 4 files changed

// File: rtl/tc_mul_lanes_pkg.sv
// Shared types for the tensor-core multiply stage: sideband layout and operand mode encoding.
package tc_pkg;

    localparam int unsigned CTRL_C_W   = 16;
    localparam int unsigned RM_W       = 3;
    localparam int unsigned REG_IDXW_W = 8;
    localparam int unsigned WARPID_W   = 4;
    localparam int unsigned CTRL_WIDTH = CTRL_C_W + RM_W + REG_IDXW_W + WARPID_W;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    typedef struct packed {
        logic [CTRL_C_W-1:0]   ctrl_c;
        logic [RM_W-1:0]       rm;
        logic [REG_IDXW_W-1:0] reg_idxw;
        logic [WARPID_W-1:0]   warpid;
    } ctrl_t;

    function automatic logic [CTRL_WIDTH-1:0] ctrl_pack(input ctrl_t c);
        return CTRL_WIDTH'(c);
    endfunction

    function automatic ctrl_t ctrl_unpack(input logic [CTRL_WIDTH-1:0] v);
        return ctrl_t'(v);
    endfunction

endpackage

// File: rtl/tc_mul_lanes_if.sv
// Operand/result bus between the operand collector, the multiply stage and the accumulator.
interface tc_mul_lanes_if #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned STAGES    = 3
);
    import tc_pkg::*;

    localparam int unsigned LANE_W = NUM_LANES * IN_WIDTH;
    localparam int unsigned PROD_W = NUM_LANES * 2 * IN_WIDTH;
    localparam int unsigned SUM_W  = 2 * IN_WIDTH + $clog2(NUM_LANES);
    localparam int unsigned OCC_W  = $clog2(STAGES) + 1;

    logic [LANE_W-1:0]     a_i;
    logic [LANE_W-1:0]     b_i;
    logic                  signed_i;
    logic [NUM_LANES-1:0]  lane_mask_i;
    logic                  reduce_i;
    logic [CTRL_WIDTH-1:0] ctrl_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [PROD_W-1:0]     prod_o;
    logic [SUM_W-1:0]      sum_o;
    logic [CTRL_WIDTH-1:0] ctrl_o;
    logic [NUM_LANES-1:0]  lane_mask_o;
    logic [OCC_W-1:0]      occupancy_o;

    modport master (
        output a_i, b_i, signed_i, lane_mask_i, reduce_i, ctrl_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, prod_o, sum_o, ctrl_o, lane_mask_o, occupancy_o
    );

    modport slave (
        input  a_i, b_i, signed_i, lane_mask_i, reduce_i, ctrl_i, in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, prod_o, sum_o, ctrl_o, lane_mask_o, occupancy_o
    );

endinterface

// File: rtl/tc_mul_lanes_stage.sv
// One valid/ready register slot; loads whenever it is empty or its contents leave this cycle.
module tc_mul_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load_c;
    assign load_c = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/tc_mul_lanes.sv
// Lane-parallel integer multiplier with masked lanes, optional dot-product reduction and a
// bubble-collapsing pipeline carrying the sideband in lock-step with the products.
module tc_mul_lanes
    import tc_pkg::*;
#(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned STAGES    = 3
) (
    input  logic         clk,
    input  logic         rst,
    tc_mul_lanes_if.slave bus
);

    localparam int unsigned PW       = 2 * IN_WIDTH;
    localparam int unsigned PROD_W   = NUM_LANES * PW;
    localparam int unsigned SUM_W    = PW + $clog2(NUM_LANES);
    localparam int unsigned OCC_W    = $clog2(STAGES) + 1;
    localparam int unsigned SGN_BIT  = PROD_W;
    localparam int unsigned MASK_LSB = PROD_W + 1;
    localparam int unsigned RED_BIT  = MASK_LSB + NUM_LANES;
    localparam int unsigned CTRL_LSB = RED_BIT + 1;
    localparam int unsigned BUN_W    = CTRL_LSB + CTRL_WIDTH;

    logic              sgn;
    logic [PROD_W-1:0] prod_c;

    assign sgn = (mode_e'(bus.signed_i) == MODE_SIGNED);

    // Operands extended by one bit so one signed multiplier serves both modes.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [IN_WIDTH:0] ax;
        logic signed [IN_WIDTH:0] bx;
        logic        [PW-1:0]     pw;

        assign ax = {sgn & bus.a_i[(l+1)*IN_WIDTH-1], bus.a_i[(l+1)*IN_WIDTH-1 -: IN_WIDTH]};
        assign bx = {sgn & bus.b_i[(l+1)*IN_WIDTH-1], bus.b_i[(l+1)*IN_WIDTH-1 -: IN_WIDTH]};
        assign pw = PW'(ax) * PW'(bx);
        assign prod_c[l*PW +: PW] = bus.lane_mask_i[l] ? pw : '0;
    end

    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;
    logic [BUN_W-1:0]  bun [STAGES+1];

    assign vld[0]      = bus.in_valid_i;
    assign bun[0]      = {bus.ctrl_i, bus.reduce_i, bus.lane_mask_i, sgn, prod_c};
    assign rdy[STAGES] = bus.out_ready_i;

    // A slot can advance unless every slot from it to the output is full and the output stalls.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign rdy[k] = bus.out_ready_i || !(&vld[STAGES:k+1]);

        tc_mul_stage #(.W(BUN_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_data   (bun[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (bun[k+1])
        );
    end

    logic [BUN_W-1:0]  fin;
    logic [PROD_W-1:0] prod_q;
    logic              sgn_q;
    logic              red_q;
    logic [SUM_W-1:0]  ext_c;
    logic [SUM_W-1:0]  sum_c;

    assign fin    = bun[STAGES];
    assign prod_q = fin[PROD_W-1:0];
    assign sgn_q  = fin[SGN_BIT];
    assign red_q  = fin[RED_BIT];

    // Reduction over the presented result, each product extended per its captured mode.
    always_comb begin
        ext_c = '0;
        sum_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            ext_c = sgn_q ? SUM_W'($signed(prod_q[l*PW +: PW])) : SUM_W'(prod_q[l*PW +: PW]);
            sum_c = sum_c + ext_c;
        end
        if (!red_q) begin
            sum_c = '0;
        end
    end

    logic             accept_c;
    logic             deliver_c;
    logic [OCC_W-1:0] occ_q;

    assign accept_c  = bus.in_valid_i && rdy[0];
    assign deliver_c = vld[STAGES] && bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (accept_c && !deliver_c) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!accept_c && deliver_c) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign bus.in_ready_o  = rdy[0];
    assign bus.out_valid_o = vld[STAGES];
    assign bus.prod_o      = prod_q;
    assign bus.sum_o       = sum_c;
    assign bus.lane_mask_o = fin[RED_BIT-1:MASK_LSB];
    assign bus.ctrl_o      = fin[BUN_W-1:CTRL_LSB];
    assign bus.occupancy_o = occ_q;

endmodule
